mb32_dma: RTL and testbench

- Bus-master block-move engine that drives the 32-bit single-port memory bus as initiator.
- It is the other end of the 32K-word SPRAM slave: it issues word reads and full-mask writes to fill or copy word ranges.
- Used by the eForth core for dictionary/stack block initialisation (fill) and for CMOVE-style word copies (copy), offloading the core.

---
 rtl/mb32_dma.sv | 136 +++++++++++++
 tb/tb_mb32_dma.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb32_dma.sv
// mb32_dma: bus-master fill/copy engine for the 32-bit SPRAM bus; MB32_DMA_CHKSUM_EN adds a running write checksum.
// Latency start->done: fill N+1, copy 2N+1, len=0 1 cycle; no backpressure, start is ignored while a command runs.
module mb32_dma #(
    parameter int AW = 15,
    parameter int LW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [31:0]   pat,
    output logic          busy,
    output logic          done,
    output logic [31:0]   chksum,
    output logic [AW-1:0] ai,
    output logic [31:0]   vi,
    output logic [3:0]    bmsk,
    output logic          we,
    input  logic [31:0]   vo
);

    typedef enum logic [2:0] {IDLE, FILL, RD, WR, FIN} state_t;

    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [LW-1:0] ONE_L = 1;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [31:0]   pat_q, pat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
        end
    end

    // Bus outputs decode from registered state only, so reset kills we at once.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        ai      = '0;
        vi      = '0;
        bmsk    = 4'h0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    rem_d = len;
                    pat_d = pat;
                    if (len == '0)
                        state_d = FIN;
                    else
                        state_d = op ? RD : FILL;
                end
            end
            FILL: begin
                ai    = dst_q;
                vi    = pat_q;
                bmsk  = 4'hF;
                we    = 1'b1;
                dst_d = dst_q + ONE_A;
                rem_d = rem_q - ONE_L;
                if (rem_q == ONE_L)
                    state_d = FIN;
            end
            RD: begin
                ai      = src_q;
                state_d = WR;
            end
            WR: begin
                // vo carries the word addressed during the preceding RD cycle.
                ai      = dst_q;
                vi      = vo;
                bmsk    = 4'hF;
                we      = 1'b1;
                src_d   = src_q + ONE_A;
                dst_d   = dst_q + ONE_A;
                rem_d   = rem_q - ONE_L;
                state_d = (rem_q == ONE_L) ? FIN : RD;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == FILL) || (state_q == RD) || (state_q == WR);
    assign done = (state_q == FIN);

`ifdef MB32_DMA_CHKSUM_EN
    logic [31:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == IDLE && start)
            chk_d = '0;
        else if (we)
            chk_d = chk_q + vi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_q <= '0;
        else
            chk_q <= chk_d;
    end

    assign chksum = chk_q;
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_mb32_dma.sv
// Bench for mb32_dma: SPRAM slave model plus a write scoreboard of expected (address, data) pairs.
module tb_mb32_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [14:0] src = '0;
    logic [14:0] dst = '0;
    logic [14:0] len = '0;
    logic [31:0] pat = '0;
    logic        busy, done, we;
    logic [31:0] chksum, vi;
    logic [14:0] ai;
    logic [3:0]  bmsk;
    logic [31:0] vo = '0;

    logic [31:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [31:0] pre_dat = '0;

    typedef struct {
        logic [14:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    mb32_dma #(.AW(15), .LW(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .pat(pat), .busy(busy), .done(done), .chksum(chksum),
        .ai(ai), .vi(vi), .bmsk(bmsk), .we(we), .vo(vo)
    );

    // Single-port slave: byte-masked write, registered read data.
    always @(posedge clk) begin
        logic [31:0] w;
        if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (we) begin
            w = mem[ai];
            for (int b = 0; b < 4; b++)
                if (bmsk[b]) w[8*b +: 8] = vi[8*b +: 8];
            mem[ai] <= w;
        end
        vo <= mem[ai];
    end

    // Advance to the next falling edge and score any bus write seen there.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (we === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write ai=%h vi=%h", ai, vi);
            end else begin
                e = exp_q.pop_front();
                if (ai !== e.a || vi !== e.d || bmsk !== 4'hF) begin
                    errors++;
                    $display("FAIL bus_write got ai=%h vi=%h bmsk=%h expected ai=%h vi=%h bmsk=f",
                             ai, vi, bmsk, e.a, e.d);
                end
            end
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_dat  = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic push(input logic [14:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge of cycle 1 after the accepting clock edge.
    task automatic issue(input logic o, input logic [14:0] s, input logic [14:0] d,
                         input logic [14:0] l, input logic [31:0] p);
        op = o; src = s; dst = d; len = l; pat = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || ai !== 15'h0 ||
            vi !== 32'h0 || bmsk !== 4'h0 || chksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b ai=%h vi=%h bmsk=%h chksum=%h expected all zero",
                     busy, done, we, ai, vi, bmsk, chksum);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        int cyc;
        preload(15'h14, 32'hA5A5_0014);
        for (int i = 0; i < 4; i++) push(15'h10 + 15'(i), 32'hDEADBEEF);
        issue(1'b0, 15'h0, 15'h10, 15'd4, 32'hDEADBEEF);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy got %b expected 1", busy);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL fill_done_cycle got %0d expected 5", cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_busy_at_done got %b expected 0", busy);
        end
`ifdef MB32_DMA_CHKSUM_EN
        checks++;
        if (chksum !== 32'h7AB6FBBC) begin
            errors++;
            $display("FAIL fill_chksum got %h expected 7ab6fbbc", chksum);
        end
`else
        checks++;
        if (chksum !== 32'h0) begin
            errors++;
            $display("FAIL fill_chksum got %h expected 0", chksum);
        end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_done_pulse got done=%b busy=%b expected 0 0", done, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fill_writes_left got %0d expected 0", exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[15'h10 + 15'(i)] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL fill_mem[%0d] got %h expected deadbeef", i, mem[15'h10 + 15'(i)]);
            end
        end
        checks++;
        if (mem[15'h14] !== 32'hA5A5_0014) begin
            errors++;
            $display("FAIL fill_untouched got %h expected a5a50014", mem[15'h14]);
        end
    endtask

    task automatic test_copy();
        int cyc;
        for (int i = 0; i < 3; i++) preload(15'h100 + 15'(i), 32'(i + 1));
        for (int i = 0; i < 3; i++) push(15'h4000 + 15'(i), 32'(i + 1));
        issue(1'b1, 15'h100, 15'h4000, 15'd3, 32'h0);
        checks++;
        if (we !== 1'b0 || ai !== 15'h100 || bmsk !== 4'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL copy_first_read got we=%b ai=%h bmsk=%h busy=%b expected 0 0100 0 1",
                     we, ai, bmsk, busy);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL copy_done_cycle got %0d expected 7", cyc);
        end
`ifdef MB32_DMA_CHKSUM_EN
        checks++;
        if (chksum !== 32'h6) begin
            errors++;
            $display("FAIL copy_chksum got %h expected 6", chksum);
        end
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL copy_writes_left got %0d expected 0", exp_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[15'h4000 + 15'(i)] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL copy_mem[%0d] got %h expected %h", i, mem[15'h4000 + 15'(i)], i + 1);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        push(15'h7FFE, 32'h5A5A5A5A);
        push(15'h7FFF, 32'h5A5A5A5A);
        push(15'h0000, 32'h5A5A5A5A);
        issue(1'b0, 15'h0, 15'h7FFE, 15'd3, 32'h5A5A5A5A);
        wait_done(1, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL wrap_done_cycle got %0d expected 4", cyc);
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || mem[15'h0] !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL wrap_result got left=%0d mem0=%h expected 0 5a5a5a5a", exp_q.size(), mem[15'h0]);
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        int w0;
        w0 = wr_cnt;
        issue(1'b0, 15'h0, 15'h200, 15'd0, 32'hFFFF0000);
        wait_done(1, cyc);
        checks++;
        if (cyc != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done got cycle=%0d busy=%b expected 1 0", cyc, busy);
        end
        tick();
        tick();
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL zero_len_writes got %0d expected 0", wr_cnt - w0);
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        preload(15'h380, 32'h0BAD0380);
        for (int i = 0; i < 8; i++) push(15'h300 + 15'(i), 32'h11112222);
        issue(1'b0, 15'h0, 15'h300, 15'd8, 32'h11112222);
        tick();
        tick();
        op = 1'b1; src = 15'h10; dst = 15'h380; len = 15'd2; pat = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, cyc);
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL busy_start_done_cycle got %0d expected 9", cyc);
        end
`ifdef MB32_DMA_CHKSUM_EN
        checks++;
        if (chksum !== 32'h88891110) begin
            errors++;
            $display("FAIL busy_start_chksum got %h expected 88891110", chksum);
        end
`endif
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || mem[15'h380] !== 32'h0BAD0380 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result got left=%0d mem380=%h busy=%b expected 0 0bad0380 0",
                     exp_q.size(), mem[15'h380], busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit saw_done;
        preload(15'h402, 32'hCAFE0402);
        push(15'h400, 32'h77777777);
        push(15'h401, 32'h77777777);
        issue(1'b0, 15'h0, 15'h400, 15'd10, 32'h77777777);
        tick();
        @(posedge clk);
        #2;
        checks++;
        if (we !== 1'b1 || ai !== 15'h402) begin
            errors++;
            $display("FAIL reset_mid_third_write got we=%b ai=%h expected 1 0402", we, ai);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bmsk !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_async got we=%b busy=%b done=%b bmsk=%h expected 0 0 0 0",
                     we, busy, done, bmsk);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || exp_q.size() != 0 || mem[15'h402] !== 32'hCAFE0402 || mem[15'h401] !== 32'h77777777) begin
            errors++;
            $display("FAIL reset_mid_abandon got done_seen=%b left=%0d mem402=%h mem401=%h expected 0 0 cafe0402 77777777",
                     saw_done, exp_q.size(), mem[15'h402], mem[15'h401]);
        end
        push(15'h410, 32'h12345678);
        issue(1'b0, 15'h0, 15'h410, 15'd1, 32'h12345678);
        wait_done(1, cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL reset_recover_done_cycle got %0d expected 2", cyc);
        end
`ifdef MB32_DMA_CHKSUM_EN
        checks++;
        if (chksum !== 32'h12345678) begin
            errors++;
            $display("FAIL reset_recover_chksum got %h expected 12345678", chksum);
        end
`endif
        tick();
        checks++;
        if (mem[15'h410] !== 32'h12345678 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_recover_mem got %h left=%0d expected 12345678 0", mem[15'h410], exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_zero_len();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
